// File: rtl/instr_mem_axi_rd_slave_if.sv
// AXI4 read-address / read-data channel bundle for the instruction memory slave.
// Both channels use standard valid/ready handshakes.
interface instr_mem_axi_rd_slave_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  // Handshake rule for AR and R: a transfer happens on a rising clk edge where
  // valid and ready are both high; once valid is raised, the source holds its
  // payload stable and keeps valid high until that transfer edge. ready may
  // change freely and is never a precondition for raising valid.

  // Read address channel
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [2:0]        s_axi_arsize;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arlock;
  logic [3:0]        s_axi_arcache;
  logic [2:0]        s_axi_arprot;
  logic [3:0]        s_axi_arqos;
  logic              s_axi_arvalid;
  logic              s_axi_arready;

  // Read data channel
  logic [ID_W-1:0]   s_axi_rid;
  logic [DATA_W-1:0] s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport master (
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    output s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
    input  s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

endinterface

// File: rtl/instr_mem_axi_rd_slave.sv
// Preloadable instruction memory served as a single-outstanding AXI4 read slave.
// Define INSTR_MEM_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP answers SLVERR.
module instr_mem_axi_rd_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 128,
  parameter int MEM_AW             = 9,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_S_AXI_BASE_ADDR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  instr_mem_axi_rd_slave_if.slave       s_axi,
  input  logic                          load_en,
  input  logic [MEM_AW-1:0]             load_addr,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] load_data,
  output logic [1:0]                    dbg_state
);

  localparam int BPB_LOG2 = $clog2(C_S_AXI_DATA_WIDTH / 8);
  localparam int WIDX_W   = C_S_AXI_ADDR_WIDTH - BPB_LOG2;
  localparam int DEPTH    = 1 << MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [C_S_AXI_ID_WIDTH-1:0] id_q, id_d;
  logic [WIDX_W-1:0]           widx_q, widx_d;
  logic [7:0]                  len_q, len_d;
  logic [1:0]                  burst_q, burst_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        burst_err_q, burst_err_d;
  logic                        beat_err_q, beat_err_d;

  logic [C_S_AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rd_q;
  logic                          mem_rd_en;

  logic                          arready;
  logic                          ar_hs;
  logic                          r_hs;
  logic                          is_last;
  logic                          widx_in_range;
  logic                          ar_burst_err;
  logic                          wrap_len_ok;
  logic [C_S_AXI_ADDR_WIDTH-1:0] ar_off;
  logic [WIDX_W-1:0]             ar_widx;
  logic [WIDX_W-1:0]             widx_next;

  // Offset from the window base; low byte-lane bits are dropped so unaligned
  // starts behave as aligned ones.
  assign ar_off  = s_axi.s_axi_araddr - C_S_AXI_BASE_ADDR;
  assign ar_widx = ar_off[C_S_AXI_ADDR_WIDTH-1:BPB_LOG2];

  assign ar_hs         = s_axi.s_axi_arvalid && arready;
  assign r_hs          = (state_q == S_DATA) && s_axi.s_axi_rready;
  assign is_last       = (cnt_q == len_q);
  assign widx_in_range = ((widx_q >> MEM_AW) == '0);

  logic unused_sigs;
  assign unused_sigs = ^{s_axi.s_axi_arlock, s_axi.s_axi_arcache, s_axi.s_axi_arprot,
                         s_axi.s_axi_arqos, ar_off[BPB_LOG2-1:0]};

`ifdef INSTR_MEM_WRAP_BURST_EN
  logic [WIDX_W-1:0] wrap_mask;
  assign wrap_mask   = WIDX_W'(len_q);
  assign wrap_len_ok = (s_axi.s_axi_arlen == 8'd1) || (s_axi.s_axi_arlen == 8'd3) ||
                       (s_axi.s_axi_arlen == 8'd7) || (s_axi.s_axi_arlen == 8'd15);
`else
  assign wrap_len_ok = 1'b0;
`endif

  // Whole-burst errors are decided once at AR time and applied to every beat.
  always_comb begin
    ar_burst_err = (s_axi.s_axi_arsize != 3'(BPB_LOG2));
    case (s_axi.s_axi_arburst)
      2'b00, 2'b01: ar_burst_err = ar_burst_err;
      2'b10:        ar_burst_err = ar_burst_err || !wrap_len_ok;
      default:      ar_burst_err = 1'b1;
    endcase
  end

  always_comb begin
    widx_next = widx_q;
    case (burst_q)
      2'b01: widx_next = widx_q + WIDX_W'(1);
`ifdef INSTR_MEM_WRAP_BURST_EN
      // Only the low log2(len+1) bits advance, so the index stays in its block.
      2'b10: widx_next = (widx_q & ~wrap_mask) | ((widx_q + WIDX_W'(1)) & wrap_mask);
`else
      2'b10: widx_next = widx_q + WIDX_W'(1);
`endif
      default: widx_next = widx_q;
    endcase
  end

  // State register and burst context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      id_q        <= '0;
      widx_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      cnt_q       <= '0;
      burst_err_q <= 1'b0;
      beat_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      widx_q      <= widx_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      cnt_q       <= cnt_d;
      burst_err_q <= burst_err_d;
      beat_err_q  <= beat_err_d;
    end
  end

  // Memory is never reset so preloaded code survives rst; reads are read-first.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
    if (mem_rd_en) begin
      mem_rd_q <= mem[widx_q[MEM_AW-1:0]];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (ar_hs) state_d = S_FETCH;
      S_FETCH: state_d = S_DATA;
      S_DATA:  if (r_hs) state_d = is_last ? S_IDLE : S_FETCH;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    id_d        = id_q;
    widx_d      = widx_q;
    len_d       = len_q;
    burst_d     = burst_q;
    cnt_d       = cnt_q;
    burst_err_d = burst_err_q;
    beat_err_d  = beat_err_q;
    case (state_q)
      S_IDLE: begin
        if (ar_hs) begin
          id_d        = s_axi.s_axi_arid;
          widx_d      = ar_widx;
          len_d       = s_axi.s_axi_arlen;
          burst_d     = s_axi.s_axi_arburst;
          cnt_d       = 8'd0;
          burst_err_d = ar_burst_err;
        end
      end
      S_FETCH: beat_err_d = burst_err_q || !widx_in_range;
      S_DATA: begin
        if (r_hs) begin
          widx_d = widx_next;
          cnt_d  = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    arready            = (state_q == S_IDLE) && !rst;
    mem_rd_en          = (state_q == S_FETCH);
    dbg_state          = state_q;
    s_axi.s_axi_arready = arready;
    s_axi.s_axi_rvalid = (state_q == S_DATA);
    s_axi.s_axi_rlast  = (state_q == S_DATA) && is_last;
    s_axi.s_axi_rresp  = ((state_q == S_DATA) && beat_err_q) ? 2'b10 : 2'b00;
    s_axi.s_axi_rdata  = ((state_q == S_DATA) && !beat_err_q) ? mem_rd_q : '0;
    s_axi.s_axi_rid    = id_q;
  end

endmodule

// File: tb/tb_instr_mem_axi_rd_slave.sv
// Directed bench for instr_mem_axi_rd_slave: preloads words, runs AXI read bursts
// and checks beats, timing, error responses and reset behaviour against a word model.
module tb_instr_mem_axi_rd_slave;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;
  localparam int MEM_AW = 9;
  localparam int PW     = ID_W + 2 + 1 + DATA_W;
`ifdef INSTR_MEM_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              load_en   = 1'b0;
  logic [MEM_AW-1:0] load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic [1:0]        dbg_state;

  instr_mem_axi_rd_slave_if #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) axi ();

  instr_mem_axi_rd_slave dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (axi.slave),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .dbg_state (dbg_state)
  );

  // Scoreboard
  logic [DATA_W-1:0] model [0:511];
  logic [PW-1:0]     exp_q[$];
  int                n_tests = 0;
  int                n_fail  = 0;
  string             cur_test = "init";

  task automatic check(string tag, logic [PW-1:0] got, logic [PW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s:%s got=%h exp=%h", cur_test, tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] observed();
    return {axi.s_axi_rid, axi.s_axi_rresp, axi.s_axi_rlast, axi.s_axi_rdata};
  endfunction

  function automatic logic [DATA_W-1:0] pat(int i);
    return {32'hC0DE0000 + 32'(i), 32'hFACE0000 + 32'(i),
            32'h12340000 + 32'(i), 32'h9ABC0000 + 32'(i)};
  endfunction

  // Expected beat k of a burst, built from the byte address and the word model.
  function automatic logic [PW-1:0] exp_beat(logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                                             logic [2:0] size, logic [1:0] burst, int k);
    logic [31:0]       idx0;
    logic [31:0]       idx;
    logic [31:0]       mask;
    logic [DATA_W-1:0] d;
    bit                err;
    idx0 = addr >> 4;
    mask = {24'h0, len};
    err  = (size != 3'd4);
    case (burst)
      2'b00: idx = idx0;
      2'b01: idx = idx0 + 32'(k);
      2'b10: begin
        if (!WRAP_EN || !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
        idx = (idx0 & ~mask) | ((idx0 + 32'(k)) & mask);
      end
      default: begin
        idx = idx0;
        err = 1'b1;
      end
    endcase
    if (idx >= 32'd512) err = 1'b1;
    d = err ? '0 : model[idx[8:0]];
    return {id, err ? 2'b10 : 2'b00, (k == int'(len)), d};
  endfunction

  // Driver tasks (called at a negedge, return at a negedge)
  task automatic do_load(int idx, logic [DATA_W-1:0] data);
    load_en   = 1'b1;
    load_addr = MEM_AW'(idx);
    load_data = data;
    model[idx] = data;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic ar_handshake(logic [3:0] id, logic [31:0] addr, logic [7:0] len,
                              logic [2:0] size, logic [1:0] burst);
    int n = 0;
    axi.s_axi_arid    = id;
    axi.s_axi_araddr  = addr;
    axi.s_axi_arlen   = len;
    axi.s_axi_arsize  = size;
    axi.s_axi_arburst = burst;
    axi.s_axi_arvalid = 1'b1;
    while (!axi.s_axi_arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ar_timeout", PW'(n), PW'(0));
    @(posedge clk);
    @(negedge clk);
    axi.s_axi_arvalid = 1'b0;
  endtask

  // Sampling point k=0 is the negedge right after the AR handshake edge, i.e. cycle 1.
  task automatic collect(int nbeats, bit toggle, bit chk_lat, bit chk_end);
    int got = 0;
    int k = 0;
    int last_lat = 0;
    bit seen = 1'b0;
    bit tog = 1'b0;
    while (got < nbeats && k < 200) begin
      if (k > 0) begin
        @(negedge clk);
        load_en = 1'b0;
      end
      axi.s_axi_rready = toggle ? tog : 1'b1;
      if (axi.s_axi_rvalid) begin
        if (!seen) begin
          seen = 1'b1;
          if (chk_lat) check("first_rvalid_lat", PW'(k + 1), PW'(2));
        end
        if (exp_q.size() == 0) begin
          check("unexpected_beat", PW'(1), PW'(0));
        end else if (axi.s_axi_rready) begin
          check("beat", observed(), exp_q.pop_front());
          got++;
          last_lat = k + 1;
        end else begin
          check("stall_hold", observed(), exp_q[0]);
        end
        tog = !tog;
      end
      k++;
    end
    check("beat_count", PW'(got), PW'(nbeats));
    if (chk_end) begin
      if (!toggle) check("burst_cycles", PW'(last_lat), PW'(2 * nbeats));
      @(negedge clk);
      check("idle_after_burst", PW'({axi.s_axi_rvalid, axi.s_axi_arready}), PW'(2'b01));
    end
  endtask

  task automatic run_burst(logic [3:0] id, logic [31:0] addr, logic [7:0] len, logic [2:0] size,
                           logic [1:0] burst, bit toggle, bit chk_lat);
    for (int k = 0; k <= int'(len); k++) exp_q.push_back(exp_beat(id, addr, len, size, burst, k));
    ar_handshake(id, addr, len, size, burst);
    collect(int'(len) + 1, toggle, chk_lat, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    axi.s_axi_arid    = '0;
    axi.s_axi_araddr  = '0;
    axi.s_axi_arlen   = '0;
    axi.s_axi_arsize  = 3'd4;
    axi.s_axi_arburst = 2'b01;
    axi.s_axi_arlock  = 1'b0;
    axi.s_axi_arcache = 4'h3;
    axi.s_axi_arprot  = 3'h4;
    axi.s_axi_arqos   = 4'h0;
    axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready  = 1'b0;

    cur_test = "reset";
    @(negedge clk);
    check("arready_in_rst", PW'(axi.s_axi_arready), PW'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arready_after_rst", PW'(axi.s_axi_arready), PW'(1));
    check("rvalid_after_rst", PW'(axi.s_axi_rvalid), PW'(0));
    check("r_outputs_after_rst", observed(), PW'(0));
    check("state_idle", PW'(dbg_state), PW'(0));

    cur_test = "preload";
    do_load(0, 128'h0123456789ABCDEF0123456789ABCDEF);
    for (int i = 1; i < 16; i++) do_load(i, pat(i));
    do_load(511, pat(511));

    cur_test = "single_beat";
    run_burst(4'h5, 32'h0000_0000, 8'd0, 3'd4, 2'b01, 1'b0, 1'b1);

    cur_test = "incr4_toggle";
    run_burst(4'h3, 32'h0000_0020, 8'd3, 3'd4, 2'b01, 1'b1, 1'b1);

    cur_test = "last_word_cross";
    run_burst(4'h7, 32'h0000_1FF0, 8'd1, 3'd4, 2'b01, 1'b0, 1'b0);

    cur_test = "wrap4";
    run_burst(4'h2, 32'h0000_0060, 8'd3, 3'd4, 2'b10, 1'b0, 1'b0);

    cur_test = "fixed_unaligned";
    run_burst(4'h1, 32'h0000_0044, 8'd2, 3'd4, 2'b00, 1'b0, 1'b0);

    cur_test = "bad_size";
    run_burst(4'h9, 32'h0000_0010, 8'd1, 3'd3, 2'b01, 1'b0, 1'b0);

    cur_test = "reserved_burst";
    run_burst(4'hA, 32'h0000_0010, 8'd1, 3'd4, 2'b11, 1'b0, 1'b0);

    cur_test = "out_of_range";
    run_burst(4'hB, 32'h0000_2000, 8'd0, 3'd4, 2'b01, 1'b0, 1'b0);

    cur_test = "incr8_long";
    run_burst(4'hC, 32'h0000_0040, 8'd7, 3'd4, 2'b01, 1'b0, 1'b1);

    // Load and fetch of word 3 land on the same edge: the beat carries the old word.
    cur_test = "read_first";
    exp_q.push_back(exp_beat(4'h6, 32'h0000_0030, 8'd0, 3'd4, 2'b01, 0));
    ar_handshake(4'h6, 32'h0000_0030, 8'd0, 3'd4, 2'b01);
    load_en   = 1'b1;
    load_addr = MEM_AW'(3);
    load_data = 128'hDEADBEEF_00000003_CAFEF00D_33333333;
    model[3]  = 128'hDEADBEEF_00000003_CAFEF00D_33333333;
    collect(1, 1'b0, 1'b0, 1'b1);
    cur_test = "read_after_load";
    run_burst(4'h6, 32'h0000_0030, 8'd0, 3'd4, 2'b01, 1'b0, 1'b0);

    cur_test = "reset_mid_burst";
    exp_q.push_back(exp_beat(4'h8, 32'h0000_0000, 8'd7, 3'd4, 2'b01, 0));
    ar_handshake(4'h8, 32'h0000_0000, 8'd7, 3'd4, 2'b01);
    collect(1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("beat2_valid", PW'(axi.s_axi_rvalid), PW'(1));
    axi.s_axi_rready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rvalid_dropped", PW'(axi.s_axi_rvalid), PW'(0));
    check("arready_in_rst", PW'(axi.s_axi_arready), PW'(0));
    rst = 1'b0;
    @(negedge clk);
    check("arready_after_release", PW'(axi.s_axi_arready), PW'(1));
    check("r_outputs_after_rst", observed(), PW'(0));
    exp_q.delete();
    cur_test = "after_reset_read";
    run_burst(4'hD, 32'h0000_0030, 8'd1, 3'd4, 2'b01, 1'b0, 1'b1);

    cur_test = "final";
    check("exp_q_drained", PW'(exp_q.size()), PW'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_axi_rd_slave.md
INSTR_MEM_AXI_RD_SLAVE -- requirements
Module: instr_mem_axi_rd_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 4, AR/R ID width.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter C_S_AXI_DATA_WIDTH, default 128, beat width (bytes per beat BPB = width/8).
REQ-004 SHALL have parameter MEM_AW, default 9, word-address width (depth 2^MEM_AW beats).
REQ-005 SHALL have parameter C_S_AXI_BASE_ADDR, default 32'h00000000, first mapped byte address.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset; one clock, sync active-high reset is decided.
REQ-007 SHALL have AR inputs: s_axi_arid ID_W, s_axi_araddr ADDR_W, s_axi_arlen 8, s_axi_arsize 3, s_axi_arburst 2, s_axi_arvalid 1; arlock/arcache/arprot/arqos accepted and ignored.
REQ-008 SHALL have s_axi_arready out 1.
REQ-009 SHALL have R outputs: s_axi_rid ID_W, s_axi_rdata DATA_W, s_axi_rresp 2, s_axi_rlast 1, s_axi_rvalid 1; input s_axi_rready 1.
REQ-010 SHALL have preload inputs: load_en 1, load_addr MEM_AW (word index), load_data DATA_W.

Function
REQ-011 SHALL store 2^MEM_AW words in synchronous-read memory, written only via load port (load_en high at posedge writes load_data).
REQ-012 SHALL implement FSM IDLE -> FETCH -> DATA -> (FETCH | IDLE); one outstanding burst only.
REQ-013 IDLE: arready=1; AR handshake captures id, start index, len, burst; next state FETCH.
REQ-014 FETCH: arready=0, memory read issued at current index; next cycle state DATA, rvalid=1.
REQ-015 DATA: rvalid, rdata, rresp, rlast, rid held stable until rready; on handshake with rlast=0 -> FETCH with next index; with rlast=1 -> IDLE.
REQ-016 Latency: first rvalid exactly 2 cycles after AR handshake cycle; one bubble cycle between consecutive beats; burst of N beats completes in 2N cycles at rready=1.
REQ-017 Word index = (araddr - BASE) >> log2(BPB); low address bits ignored (unaligned treated as aligned).
REQ-018 INCR: index+1 per beat; FIXED: index constant.
REQ-019 Any beat whose byte address falls outside [BASE, BASE + BPB*2^MEM_AW) SHALL return rresp=2'b10 (SLVERR), rdata=0; in-range beats rresp=2'b00.
REQ-020 arsize != log2(BPB) SHALL return SLVERR on every beat of that burst; beat count still arlen+1.
REQ-021 rlast=1 only on beat arlen+1; rid = captured arid on every beat.
REQ-022 Load write and fetch to same index in same cycle SHALL return old data (read-first).
REQ-023 Reserved burst type 2'b11 SHALL return SLVERR on all arlen+1 beats.

Reset
REQ-024 rst SHALL force state IDLE, arready=1 cycle after release, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0.
REQ-025 rst mid-burst SHALL drop rvalid next posedge and abandon remaining beats; memory contents SHALL be retained.
REQ-026 During rst arready SHALL be 0.

Configuration
REQ-027 Macro INSTR_MEM_WRAP_BURST_EN defined: WRAP (2'b10) supported for arlen 1/3/7/15; index wraps within (arlen+1)-beat aligned block; other arlen with WRAP -> SLVERR all beats.
REQ-028 Macro undefined: WRAP bursts SHALL return SLVERR, rdata=0, on all arlen+1 beats.

Verification
REQ-029 Preload word 0 = 128'h0123..EF, AR addr=BASE, len=0, INCR, rready=1 -> one beat, data matches, rresp=00, rlast=1, rvalid 2 cycles after AR.
REQ-030 INCR len=3 at addr 0x20, rready toggling 1/0 -> beats words 2..5 in order, data stable while rready=0, rlast on 4th only.
REQ-031 AR at last word (index 511) INCR len=1 -> beat 1 OKAY, beat 2 SLVERR rdata=0.
REQ-032 WRAP len=3 at index 6: macro defined -> indices 6,7,4,5 OKAY; undefined -> 4 SLVERR beats.
REQ-033 rst asserted after beat 1 of len=7 burst -> rvalid=0 next cycle, arready=1 after release, new AR served correctly with preloaded data intact.
REQ-034 load_en to index 3 same cycle as fetch of index 3 -> returned beat holds old value; next read returns new.
